// File: rtl/dpram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
//   NREQ         number of requesters sharing the RAM
//   BYTES        byte lanes per RAM word (data width is fixed at 64)
//   req_id_t     requester index
//   addr_overlap true when an 8-byte read window touches an 8-byte write window,
//                wrapping modulo the RAM size
package dpram_arb_pkg;

   localparam int unsigned NREQ     = 2;
   localparam int unsigned DW_LEGAL = 64;
   localparam int unsigned BYTES    = DW_LEGAL / 8;

   typedef logic req_id_t;

   // d is the forward distance from write start to read start; the windows are
   // disjoint only when the read starts at least BYTES past the write and ends
   // before the write starts again (distance <= size - BYTES).
   function automatic logic addr_overlap(input logic [31:0]  waddr,
                                         input logic [31:0]  raddr,
                                         input int unsigned  size);
      logic [31:0] d;
      d = (raddr - waddr) & (size - 32'd1);
      return (d < BYTES) || (d > (size - BYTES));
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n  clock, asynchronous active-low reset
//   req[1:0]    requests
//   upd         commit the current grant; priority moves away from the winner
//   grant[1:0]  one-hot grant, combinational from req and the priority register
module rr_arb2
   import dpram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] grant
);

   req_id_t pri_q;

   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = pri_q ? 2'b10 : 2'b01;
      end else begin
         grant = req;
      end
   end

   // Winner r0 hands priority to r1 and vice versa.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pri_q <= 1'b0;
      end else if (upd) begin
         pri_q <= grant[0];
      end
   end

endmodule

// File: rtl/dpram_arb2.sv
// Shares one dual-port RAM between two requesters. The write port and read port
// are arbitrated independently (round-robin each), so one write and one read
// can be granted in the same cycle to different requesters. A read that
// overlaps the same-cycle write is held one cycle when HAZARD_STALL is set.
//   clk, rst_n                   clock, asynchronous active-low reset
//   rN_valid/we/addr/wdata       request (we == 0 means read), N = 0,1
//   rN_ready                     request accepted this cycle
//   rN_rsp_valid/rsp_rdata       response one cycle after acceptance
//   mem_we/din/waddr/raddr       to RAM
//   mem_dout                     from RAM, one cycle after raddr
module dpram_arb2
   import dpram_arb_pkg::*;
#(
   parameter int unsigned SIZE         = 65536,
   parameter int unsigned DW           = 64,
   parameter int unsigned HAZARD_STALL = 1,
   localparam int unsigned AW          = $clog2(SIZE)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            r0_valid,
   output logic            r0_ready,
   input  logic [DW/8-1:0] r0_we,
   input  logic [AW-1:0]   r0_addr,
   input  logic [DW-1:0]   r0_wdata,
   output logic            r0_rsp_valid,
   output logic [DW-1:0]   r0_rsp_rdata,
   input  logic            r1_valid,
   output logic            r1_ready,
   input  logic [DW/8-1:0] r1_we,
   input  logic [AW-1:0]   r1_addr,
   input  logic [DW-1:0]   r1_wdata,
   output logic            r1_rsp_valid,
   output logic [DW-1:0]   r1_rsp_rdata,
   output logic [DW/8-1:0] mem_we,
   output logic [DW-1:0]   mem_din,
   output logic [AW-1:0]   mem_waddr,
   output logic [AW-1:0]   mem_raddr,
   input  logic [DW-1:0]   mem_dout
);

   logic [DW/8-1:0] we    [NREQ];
   logic [AW-1:0]   addr  [NREQ];
   logic [DW-1:0]   wdata [NREQ];

   logic [NREQ-1:0] valid, is_wr, is_rd;
   logic [NREQ-1:0] wr_gnt, rd_gnt_raw, rd_gnt, ready;
   logic [NREQ-1:0] rsp_vld_q, rsp_isrd_q;
   logic [AW-1:0]   raddr_q;
   req_id_t         wr_id, rd_id;
   logic            hazard;

   assign we[0]    = r0_we;
   assign we[1]    = r1_we;
   assign addr[0]  = r0_addr;
   assign addr[1]  = r1_addr;
   assign wdata[0] = r0_wdata;
   assign wdata[1] = r1_wdata;

   // Gating with rst_n keeps ready and all RAM strobes low during reset.
   assign valid = {r1_valid, r0_valid} & {NREQ{rst_n}};

   always_comb begin
      is_wr = '0;
      is_rd = '0;
      for (int n = 0; n < NREQ; n++) begin
         is_wr[n] = valid[n] & (|we[n]);
         is_rd[n] = valid[n] & ~(|we[n]);
      end
   end

   rr_arb2 u_wr_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (is_wr),
      .upd   (|wr_gnt),
      .grant (wr_gnt)
   );

   // Read priority advances only on a read that actually goes out, so a
   // stalled read keeps its turn.
   rr_arb2 u_rd_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (is_rd),
      .upd   (|rd_gnt),
      .grant (rd_gnt_raw)
   );

   assign wr_id = wr_gnt[1];
   assign rd_id = rd_gnt_raw[1];

   assign hazard = (HAZARD_STALL != 0) && (|wr_gnt) && (|rd_gnt_raw) &&
                   addr_overlap(32'(addr[wr_id]), 32'(addr[rd_id]), SIZE);

   assign rd_gnt = hazard ? '0 : rd_gnt_raw;
   assign ready  = wr_gnt | rd_gnt;

   assign r0_ready = ready[0];
   assign r1_ready = ready[1];

   always_comb begin
      mem_we    = '0;
      mem_waddr = '0;
      mem_din   = '0;
      if (|wr_gnt) begin
         mem_we    = we[wr_id];
         mem_waddr = addr[wr_id];
         mem_din   = wdata[wr_id];
      end
   end

   // Read address holds its last value when no read is granted.
   assign mem_raddr = (|rd_gnt) ? addr[rd_id] : raddr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld_q  <= '0;
         rsp_isrd_q <= '0;
         raddr_q    <= '0;
      end else begin
         rsp_vld_q  <= ready;
         rsp_isrd_q <= rd_gnt;
         if (|rd_gnt) begin
            raddr_q <= addr[rd_id];
         end
      end
   end

   assign r0_rsp_valid = rsp_vld_q[0];
   assign r1_rsp_valid = rsp_vld_q[1];
   assign r0_rsp_rdata = (rsp_vld_q[0] & rsp_isrd_q[0]) ? mem_dout : '0;
   assign r1_rsp_rdata = (rsp_vld_q[1] & rsp_isrd_q[1]) ? mem_dout : '0;

endmodule

// File: tb/tb_dpram_arb2.sv
module tb_dpram_arb2;

   localparam int SIZE = 4096;
   localparam int AW   = 12;

   logic            clk;
   logic            rst_n;
   logic [1:0]      rv;
   logic [7:0]      rwe    [2];
   logic [AW-1:0]   raddr  [2];
   logic [63:0]     rwdata [2];
   logic            r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
   logic [63:0]     r0_rsp_rdata, r1_rsp_rdata;
   logic [7:0]      mem_we;
   logic [63:0]     mem_din, mem_dout;
   logic [AW-1:0]   mem_waddr, mem_raddr;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [7:0]  ref_mem [SIZE];
   bit          m_wpri, m_rpri;
   int          m_raddr_last;
   logic [1:0]  dut_rdy;
   logic [63:0] last_rdata [2];

   // Byte-addressed RAM stand-in with registered read, wrapping at SIZE
   logic [7:0] ram [SIZE];

   dpram_arb2 #(
      .SIZE         (SIZE),
      .DW           (64),
      .HAZARD_STALL (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .r0_valid     (rv[0]),
      .r0_ready     (r0_ready),
      .r0_we        (rwe[0]),
      .r0_addr      (raddr[0]),
      .r0_wdata     (rwdata[0]),
      .r0_rsp_valid (r0_rsp_valid),
      .r0_rsp_rdata (r0_rsp_rdata),
      .r1_valid     (rv[1]),
      .r1_ready     (r1_ready),
      .r1_we        (rwe[1]),
      .r1_addr      (raddr[1]),
      .r1_wdata     (rwdata[1]),
      .r1_rsp_valid (r1_rsp_valid),
      .r1_rsp_rdata (r1_rsp_rdata),
      .mem_we       (mem_we),
      .mem_din      (mem_din),
      .mem_waddr    (mem_waddr),
      .mem_raddr    (mem_raddr),
      .mem_dout     (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (mem_we[i]) ram[(int'(mem_waddr) + i) % SIZE] <= mem_din[8*i +: 8];
         mem_dout[8*i +: 8] <= ram[(int'(mem_raddr) + i) % SIZE];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit overlaps(input int wa, input int ra);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if ((wa + i) % SIZE == (ra + j) % SIZE) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [63:0] ref_read(input int a);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[(a + i) % SIZE];
      return r;
   endfunction

   // One cycle: entered at posedge+1 with inputs set, returns at next posedge+1.
   task automatic step();
      bit          wr [2];
      bit          rd [2];
      bit          acc [2];
      int          wg, rg;
      logic [63:0] rdat;
      logic [63:0] exp_ra;
      #1;
      for (int n = 0; n < 2; n++) begin
         wr[n] = rv[n] && (rwe[n] != 8'h00);
         rd[n] = rv[n] && (rwe[n] == 8'h00);
      end
      wg = -1;
      if (wr[0] && wr[1]) wg = int'(m_wpri);
      else if (wr[0]) wg = 0;
      else if (wr[1]) wg = 1;
      rg = -1;
      if (rd[0] && rd[1]) rg = int'(m_rpri);
      else if (rd[0]) rg = 0;
      else if (rd[1]) rg = 1;
      if (wg >= 0 && rg >= 0 && overlaps(int'(raddr[wg]), int'(raddr[rg]))) rg = -1;
      for (int n = 0; n < 2; n++) acc[n] = (wg == n) || (rg == n);

      dut_rdy = {r1_ready, r0_ready};
      check("r0_ready", 64'(r0_ready), 64'(acc[0]));
      check("r1_ready", 64'(r1_ready), 64'(acc[1]));
      check("mem_we", 64'(mem_we), (wg >= 0) ? 64'(rwe[wg]) : 64'd0);
      check("mem_waddr", 64'(mem_waddr), (wg >= 0) ? 64'(raddr[wg]) : 64'd0);
      check("mem_din", mem_din, (wg >= 0) ? rwdata[wg] : 64'd0);
      exp_ra = (rg >= 0) ? 64'(raddr[rg]) : 64'(m_raddr_last);
      check("mem_raddr", 64'(mem_raddr), exp_ra);

      rdat = (rg >= 0) ? ref_read(int'(raddr[rg])) : 64'd0;
      if (wg >= 0) begin
         for (int i = 0; i < 8; i++)
            if (rwe[wg][i]) ref_mem[(int'(raddr[wg]) + i) % SIZE] = rwdata[wg][8*i +: 8];
         m_wpri = (wg == 0);
      end
      if (rg >= 0) begin
         m_rpri       = (rg == 0);
         m_raddr_last = int'(raddr[rg]);
      end

      @(posedge clk);
      #1;
      check("r0_rsp_valid", 64'(r0_rsp_valid), 64'(acc[0]));
      check("r1_rsp_valid", 64'(r1_rsp_valid), 64'(acc[1]));
      check("r0_rsp_rdata", r0_rsp_rdata, (rg == 0) ? rdat : 64'd0);
      check("r1_rsp_rdata", r1_rsp_rdata, (rg == 1) ? rdat : 64'd0);
      if (r0_rsp_valid) last_rdata[0] = r0_rsp_rdata;
      if (r1_rsp_valid) last_rdata[1] = r1_rsp_rdata;
      for (int n = 0; n < 2; n++) if (acc[n]) rv[n] = 1'b0;
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (rv != 2'b00 && c < budget) begin
         step();
         c++;
      end
      check("drain", 64'(rv), 64'd0);
      if (rv != 2'b00) rv = 2'b00;
   endtask

   task automatic set_req(input int n, input logic [7:0] we, input int a, input logic [63:0] d);
      rv[n]     = 1'b1;
      rwe[n]    = we;
      raddr[n]  = AW'(a);
      rwdata[n] = d;
   endtask

   task automatic model_reset();
      m_wpri       = 1'b0;
      m_rpri       = 1'b0;
      m_raddr_last = 0;
   endtask

   task automatic new_req(input int n);
      if ($urandom_range(0, 9) < 8) begin
         rv[n]     = 1'b1;
         rwe[n]    = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255));
         raddr[n]  = ($urandom_range(0, 2) != 0) ? AW'((4084 + $urandom_range(0, 24)) % SIZE)
                                                 : AW'($urandom_range(0, SIZE - 1));
         rwdata[n] = {$urandom, $urandom};
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      rv    = 2'b00;
      for (int n = 0; n < 2; n++) begin
         rwe[n] = 8'h00; raddr[n] = '0; rwdata[n] = '0; last_rdata[n] = '0;
      end
      for (int a = 0; a < SIZE; a++) begin
         ref_mem[a] = 8'($urandom);
         ram[a]     = ref_mem[a];
      end
      model_reset();
      #2 rst_n = 1'b0;

      // Reset state, with requests present on both channels
      set_req(0, 8'hFF, 12'h010, 64'h1);
      set_req(1, 8'h00, 12'h020, 64'h0);
      #3;
      check("rst_r0_ready", 64'(r0_ready), 64'd0);
      check("rst_r1_ready", 64'(r1_ready), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_raddr", 64'(mem_raddr), 64'd0);
      check("rst_rsp_valid", 64'({r1_rsp_valid, r0_rsp_valid}), 64'd0);
      check("rst_rdata", r0_rsp_rdata | r1_rsp_rdata, 64'd0);
      rv = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Continuous writes from both: strict alternation starting with r0
      for (int k = 0; k < 8; k++) begin
         if (!rv[0]) set_req(0, 8'hFF, 12'h200, {32'h2000_0000, 32'(k)});
         if (!rv[1]) set_req(1, 8'hFF, 12'h300, {32'h3000_0000, 32'(k)});
         step();
         check("t2_alt_r0", 64'(dut_rdy[0]), 64'(k % 2 == 0));
         check("t2_alt_r1", 64'(dut_rdy[1]), 64'(k % 2 == 1));
      end
      drain(4);

      // Write then read back
      set_req(0, 8'hFF, 12'h100, 64'h1122334455667788);
      drain(4);
      set_req(1, 8'h00, 12'h100, 64'h0);
      drain(4);
      check("t1_rdata", last_rdata[1], 64'h1122334455667788);

      // Overlapping read is held one cycle and then sees the new bytes
      set_req(0, 8'h0F, 12'h208, 64'h0000_0000_DEADBEEF);
      set_req(1, 8'h00, 12'h204, 64'h0);
      step();
      check("t3_wr_ready", 64'(dut_rdy[0]), 64'd1);
      check("t3_rd_stall", 64'(dut_rdy[1]), 64'd0);
      drain(4);
      check("t3_new_bytes", 64'(last_rdata[1][63:32]), 64'hDEADBEEF);

      // Wrap-around overlap at the top of memory
      set_req(0, 8'hFF, 12'hFFC, 64'hCAFE_F00D_1234_5678);
      set_req(1, 8'h00, 12'h002, 64'h0);
      step();
      check("t4_wrap_stall", 64'(dut_rdy[1]), 64'd0);
      drain(4);
      set_req(0, 8'hFF, 12'hFFC, 64'h0BAD_BEEF_8765_4321);
      set_req(1, 8'h00, 12'h008, 64'h0);
      step();
      check("t4_no_stall", 64'(dut_rdy[1]), 64'd1);
      drain(4);

      // Partial byte enables
      set_req(0, 8'hFF, 12'h400, 64'h0123456789ABCDEF);
      drain(4);
      set_req(0, 8'h81, 12'h400, 64'hAACCCCCCCCCCCCBB);
      drain(4);
      set_req(1, 8'h00, 12'h400, 64'h0);
      drain(4);
      check("t5_rdata", last_rdata[1], 64'hAA23456789ABCDBB);

      // Reset right after a read is accepted drops its response
      set_req(1, 8'h00, 12'h100, 64'h0);
      #1;
      check("t6_accept", 64'(r1_ready), 64'd1);
      @(posedge clk);
      rst_n = 1'b0;
      rv    = 2'b00;
      #1;
      check("t6_rsp_dropped", 64'(r1_rsp_valid), 64'd0);
      check("t6_rdata_zero", r1_rsp_rdata, 64'd0);
      set_req(0, 8'hFF, 12'h040, 64'h5);
      set_req(1, 8'h00, 12'h080, 64'h0);
      #1;
      check("t6_rst_ready", 64'({r1_ready, r0_ready}), 64'd0);
      check("t6_rst_raddr", 64'(mem_raddr), 64'd0);
      rv = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      repeat (3) step();
      set_req(0, 8'hFF, 12'h500, 64'h55);
      set_req(1, 8'hFF, 12'h600, 64'h66);
      step();
      check("t6_pri_r0", 64'(dut_rdy), 64'b01);
      drain(4);

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         for (int n = 0; n < 2; n++) if (!rv[n]) new_req(n);
         step();
      end
      drain(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
